// File: rtl/nv_nvdla_mcif_write_ig_wrr_sched.sv
// Write-ingress weighted round-robin scheduler: picks one of sdp/pdp/cdp under an
// outstanding-beat credit limit, then routes that command's data beats.
module nv_nvdla_mcif_write_ig_wrr_sched (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic [2:0] req_valid,
    input  logic [5:0] req_len,
    output logic [2:0] req_ready,
    input  logic [7:0] reg2dp_wr_weight_sdp,
    input  logic [7:0] reg2dp_wr_weight_pdp,
    input  logic [7:0] reg2dp_wr_weight_cdp,
    input  logic [7:0] reg2dp_wr_os_cnt,
    input  logic       eg2ig_axi_vld,
    input  logic [1:0] eg2ig_axi_len,
    output logic       gnt_valid,
    input  logic       gnt_ready,
    output logic [1:0] gnt_id,
    output logic [1:0] gnt_len,
    output logic       dat_busy,
    output logic [1:0] dat_sel,
    input  logic       dat_accept,
    output logic [8:0] os_used,
    output logic       os_err,
    output logic [1:0] fsm_state
);

    // gnt_valid/gnt_ready: a command transfers on any cycle where both are high;
    // gnt_id/gnt_len stay stable from gnt_valid rise until that cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [7:0] wt_left [3];
    logic [7:0] wt_cfg  [3];
    logic [1:0] len_c   [3];
    logic [1:0] beat_cnt;
    logic [2:0] credit_ok, elig;
    logic       win_found, reload, arb_go, cmd_hs, last_beat, underflow;
    logic [1:0] win_id, scan_idx;
    logic [2:0] scan_sum;
    logic [9:0] os_limit, os_add, os_sub, os_sum;
    logic [8:0] os_next;

    assign wt_cfg[0] = reg2dp_wr_weight_sdp;
    assign wt_cfg[1] = reg2dp_wr_weight_pdp;
    assign wt_cfg[2] = reg2dp_wr_weight_cdp;
    assign len_c[0]  = req_len[1:0];
    assign len_c[1]  = req_len[3:2];
    assign len_c[2]  = req_len[5:4];
    assign os_limit  = {2'd0, reg2dp_wr_os_cnt} + 10'd1;

    always_comb begin
        credit_ok = 3'b000;
        elig      = 3'b000;
        for (int c = 0; c < 3; c++) begin
            credit_ok[c] = ({1'b0, os_used} + {8'd0, len_c[c]} + 10'd1) <= os_limit;
            elig[c]      = req_valid[c] && credit_ok[c] && (wt_left[c] != 8'd0);
        end
    end

    // Scan ptr, ptr+1, ptr+2 modulo 3; first eligible client wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = 2'd0;
        scan_sum  = 3'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            scan_sum = {1'b0, ptr} + 3'(k);
            scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
            if (!win_found && elig[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    assign arb_go = (state == ST_IDLE) && win_found;
    assign reload = (state == ST_IDLE) && !win_found && |(req_valid & credit_ok);

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) state <= ST_IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt_valid = 1'b0;
        dat_busy  = 1'b0;
        req_ready = 3'b000;
        cmd_hs    = 1'b0;
        last_beat = 1'b0;
        case (state)
            ST_IDLE: if (win_found) state_nxt = ST_CMD;
            ST_CMD: begin
                gnt_valid = 1'b1;
                if (gnt_ready) begin
                    cmd_hs    = 1'b1;
                    req_ready = 3'b001 << gnt_id;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                dat_busy = 1'b1;
                if (dat_accept && (beat_cnt == gnt_len)) begin
                    last_beat = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dat_sel   = dat_busy ? gnt_id : 2'd0;
    assign fsm_state = state;

    // Add and retire net out in one cycle; a retire larger than the total clamps to 0.
    always_comb begin
        os_add    = cmd_hs ? ({8'd0, gnt_len} + 10'd1) : 10'd0;
        os_sub    = eg2ig_axi_vld ? ({8'd0, eg2ig_axi_len} + 10'd1) : 10'd0;
        os_sum    = {1'b0, os_used} + os_add;
        underflow = os_sub > os_sum;
        os_next   = underflow ? 9'd0 : 9'(os_sum - os_sub);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            ptr      <= 2'd0;
            gnt_id   <= 2'd0;
            gnt_len  <= 2'd0;
            beat_cnt <= 2'd0;
            os_used  <= 9'd0;
            os_err   <= 1'b0;
            for (int c = 0; c < 3; c++) wt_left[c] <= 8'd0;
        end else begin
            if (arb_go) begin
                gnt_id          <= win_id;
                gnt_len         <= len_c[win_id];
                wt_left[win_id] <= wt_left[win_id] - 8'd1;
                if (wt_left[win_id] == 8'd1) ptr <= (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
            end else if (reload) begin
                for (int c = 0; c < 3; c++)
                    wt_left[c] <= (wt_cfg[c] == 8'd0) ? 8'd1 : wt_cfg[c];
            end
            if (state == ST_DATA && dat_accept)
                beat_cnt <= last_beat ? 2'd0 : beat_cnt + 2'd1;
            os_used <= os_next;
            if (underflow) os_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_mcif_write_ig_wrr_sched.sv
// Directed bench for the WRR write scheduler: arbitration vector table plus
// hand-written multi-cycle sequences for credit, stall, retire and reset cases.
module tb_nv_nvdla_mcif_write_ig_wrr_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] req_valid;
    logic [5:0] req_len;
    logic [2:0] req_ready;
    logic [7:0] w_sdp, w_pdp, w_cdp, os_cnt;
    logic       eg_vld;
    logic [1:0] eg_len;
    logic       gnt_valid, gnt_ready;
    logic [1:0] gnt_id, gnt_len;
    logic       dat_busy, dat_accept;
    logic [1:0] dat_sel;
    logic [8:0] os_used;
    logic       os_err;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    nv_nvdla_mcif_write_ig_wrr_sched dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .reg2dp_wr_weight_sdp(w_sdp), .reg2dp_wr_weight_pdp(w_pdp),
        .reg2dp_wr_weight_cdp(w_cdp), .reg2dp_wr_os_cnt(os_cnt),
        .eg2ig_axi_vld(eg_vld), .eg2ig_axi_len(eg_len),
        .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt_id(gnt_id), .gnt_len(gnt_len),
        .dat_busy(dat_busy), .dat_sel(dat_sel), .dat_accept(dat_accept),
        .os_used(os_used), .os_err(os_err), .fsm_state(fsm_state)
    );

    typedef struct {
        logic [2:0] valid;
        logic [5:0] len;
        logic [7:0] w0, w1, w2, os;
        logic       exp_grant;
        logic [1:0] exp_id, exp_len;
    } vec_t;

    vec_t       vecs [7];
    logic [1:0] exp_q [$];
    logic [1:0] exp_id;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         got;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic defaults();
        req_valid = 3'b000; req_len = 6'd0; gnt_ready = 1'b0; dat_accept = 1'b0;
        eg_vld = 1'b0; eg_len = 2'd0;
        w_sdp = 8'd1; w_pdp = 8'd1; w_cdp = 8'd1; os_cnt = 8'd255;
    endtask

    task automatic wait_gnt(input string name, input int max);
        int k;
        k = 0;
        while (!gnt_valid && k < max) begin
            tick();
            k++;
        end
        if (!gnt_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: gnt_valid timeout after %0d cycles", name, max);
        end
    endtask

    initial begin
        defaults();
        rstn = 1'b0;
        tick();
        tick();
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_dat_busy", dat_busy, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_gnt_len", gnt_len, 0);
        check("rst_dat_sel", dat_sel, 0);
        check("rst_os_used", os_used, 0);
        check("rst_os_err", os_err, 0);
        rstn = 1'b1;

        // lengths packed {c2, c1, c0}
        vecs[0] = '{3'b001, {2'd0, 2'd0, 2'd2}, 8'd1, 8'd1, 8'd1, 8'd255, 1'b1, 2'd0, 2'd2};
        vecs[1] = '{3'b110, {2'd3, 2'd1, 2'd0}, 8'd1, 8'd1, 8'd1, 8'd255, 1'b1, 2'd1, 2'd1};
        vecs[2] = '{3'b100, {2'd3, 2'd0, 2'd0}, 8'd1, 8'd1, 8'd1, 8'd255, 1'b1, 2'd2, 2'd3};
        vecs[3] = '{3'b111, {2'd2, 2'd0, 2'd1}, 8'd1, 8'd1, 8'd1, 8'd0,   1'b1, 2'd1, 2'd0};
        vecs[4] = '{3'b111, {2'd2, 2'd3, 2'd3}, 8'd1, 8'd1, 8'd1, 8'd2,   1'b1, 2'd2, 2'd2};
        vecs[5] = '{3'b010, {2'd0, 2'd0, 2'd0}, 8'd0, 8'd0, 8'd0, 8'd255, 1'b1, 2'd1, 2'd0};
        vecs[6] = '{3'b001, {2'd0, 2'd0, 2'd1}, 8'd1, 8'd1, 8'd1, 8'd0,   1'b0, 2'd0, 2'd0};

        for (int i = 0; i < 7; i++) begin
            defaults();
            req_valid = vecs[i].valid; req_len = vecs[i].len;
            w_sdp = vecs[i].w0; w_pdp = vecs[i].w1; w_cdp = vecs[i].w2; os_cnt = vecs[i].os;
            do_reset();
            tick();
            check($sformatf("v%0d_bubble", i), gnt_valid, 0);
            tick();
            check($sformatf("v%0d_gnt_valid", i), gnt_valid, vecs[i].exp_grant);
            if (vecs[i].exp_grant) begin
                check($sformatf("v%0d_gnt_id", i), gnt_id, vecs[i].exp_id);
                check($sformatf("v%0d_gnt_len", i), gnt_len, vecs[i].exp_len);
                gnt_ready = 1'b1;
                #1;
                check($sformatf("v%0d_req_ready", i), req_ready, 3'b001 << vecs[i].exp_id);
                tick();
                gnt_ready = 1'b0;
                req_valid = 3'b000;
                check($sformatf("v%0d_os_used", i), os_used, {7'd0, vecs[i].exp_len} + 9'd1);
                check($sformatf("v%0d_dat_sel", i), dat_sel, vecs[i].exp_id);
                dat_accept = 1'b1;
                repeat (int'(vecs[i].exp_len)) tick();
                check($sformatf("v%0d_busy_last", i), dat_busy, 1);
                tick();
                check($sformatf("v%0d_busy_done", i), dat_busy, 0);
            end else begin
                repeat (5) tick();
                check($sformatf("v%0d_still_blocked", i), gnt_valid, 0);
                check($sformatf("v%0d_os_used", i), os_used, 0);
            end
        end

        // WRR order with weights 2/1/1, all clients always requesting
        defaults();
        w_sdp = 8'd2; req_valid = 3'b111; gnt_ready = 1'b1; dat_accept = 1'b1;
        exp_q = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
        do_reset();
        got = 0;
        for (int k = 0; k < 80 && got < 8; k++) begin
            tick();
            if (gnt_valid) begin
                exp_id = exp_q.pop_front();
                check("wrr_gnt_id", gnt_id, exp_id);
                check("wrr_req_ready", req_ready, 3'b001 << exp_id);
                got++;
            end
        end
        check("wrr_grant_count", got, 8);

        // credit block and release by retire
        defaults();
        os_cnt = 8'd3; req_valid = 3'b010; req_len = {2'd0, 2'd3, 2'd0};
        gnt_ready = 1'b1; dat_accept = 1'b1;
        do_reset();
        wait_gnt("credit_first", 10);
        check("credit_gnt_id", gnt_id, 1);
        tick();
        repeat (4) tick();
        check("credit_os_used", os_used, 4);
        check("credit_data_done", dat_busy, 0);
        repeat (5) tick();
        check("credit_blocked", gnt_valid, 0);
        check("credit_os_held", os_used, 4);
        eg_vld = 1'b1; eg_len = 2'd3;
        tick();
        eg_vld = 1'b0;
        check("credit_retired", os_used, 0);
        tick();
        check("credit_reload_bubble", gnt_valid, 0);
        tick();
        check("credit_regrant", gnt_valid, 1);
        check("credit_regrant_id", gnt_id, 1);

        // gnt_ready stall in CMD, dat_accept held high there must not count beats
        defaults();
        req_valid = 3'b001; req_len = 6'd2; dat_accept = 1'b1;
        do_reset();
        wait_gnt("stall_grant", 10);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_gnt_valid", gnt_valid, 1);
            check("stall_gnt_id", gnt_id, 0);
            check("stall_gnt_len", gnt_len, 2);
            check("stall_req_ready", req_ready, 0);
            check("stall_os_used", os_used, 0);
        end
        gnt_ready = 1'b1;
        #1;
        check("stall_hs_req_ready", req_ready, 3'b001);
        tick();
        gnt_ready = 1'b0; req_valid = 3'b000;
        check("stall_os_after_hs", os_used, 3);
        check("stall_busy", dat_busy, 1);
        tick();
        tick();
        check("stall_busy_beat3", dat_busy, 1);
        tick();
        check("stall_busy_done", dat_busy, 0);

        // simultaneous command add and retire
        defaults();
        req_valid = 3'b001; req_len = 6'd2; dat_accept = 1'b1;
        do_reset();
        wait_gnt("net_first", 10);
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0; req_len = 6'd1;
        wait_gnt("net_second", 20);
        check("net_os_before", os_used, 3);
        check("net_gnt_len", gnt_len, 1);
        gnt_ready = 1'b1; eg_vld = 1'b1; eg_len = 2'd0;
        tick();
        gnt_ready = 1'b0; eg_vld = 1'b0; req_valid = 3'b000;
        check("net_os_after", os_used, 4);
        check("net_os_err", os_err, 0);

        // retire underflow is sticky until reset
        defaults();
        req_valid = 3'b001; gnt_ready = 1'b1; dat_accept = 1'b1;
        do_reset();
        wait_gnt("uf_grant", 10);
        tick();
        req_valid = 3'b000;
        tick();
        check("uf_os_before", os_used, 1);
        eg_vld = 1'b1; eg_len = 2'd3;
        tick();
        eg_vld = 1'b0;
        check("uf_os_clamped", os_used, 0);
        check("uf_err_set", os_err, 1);
        repeat (3) tick();
        check("uf_err_sticky", os_err, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("uf_err_cleared", os_err, 0);

        // reset in the middle of a 4-beat data phase
        defaults();
        req_valid = 3'b010; req_len = {2'd0, 2'd3, 2'd0}; gnt_ready = 1'b1;
        do_reset();
        wait_gnt("mid_grant", 10);
        tick();
        check("mid_busy", dat_busy, 1);
        check("mid_dat_sel", dat_sel, 1);
        dat_accept = 1'b1;
        tick();
        rstn = 1'b0;
        req_valid = 3'b111; req_len = 6'd0;
        tick();
        check("mid_gnt_valid", gnt_valid, 0);
        check("mid_req_ready", req_ready, 0);
        check("mid_dat_busy", dat_busy, 0);
        check("mid_gnt_id", gnt_id, 0);
        check("mid_gnt_len", gnt_len, 0);
        check("mid_dat_sel", dat_sel, 0);
        check("mid_os_used", os_used, 0);
        check("mid_state", fsm_state, 0);
        rstn = 1'b1;
        tick();
        tick();
        check("mid_ptr_grant", gnt_valid, 1);
        check("mid_ptr_id", gnt_id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_mcif_write_ig_wrr_sched.md
NV_NVDLA_MCIF_WRITE_IG_WRR_SCHED -- requirements
Module: NV_NVDLA_MCIF_WRITE_IG_wrr_sched

Interface
REQ-001 SHALL have parameters: none; client map fixed: 0=sdp, 1=pdp, 2=cdp.
REQ-002 SHALL have port nvdla_core_clk  in  1  sole clock; everything is rising-edge synchronous to it.
REQ-003 SHALL have port nvdla_core_rstn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  3  per-client command request.
REQ-005 SHALL have port req_len  in  6  per-client burst length minus 1 ([1:0]=client0, [3:2]=client1, [5:4]=client2), 1..4 beats.
REQ-006 SHALL have port req_ready  out  3  per-client command-consumed pulse.
REQ-007 SHALL have ports reg2dp_wr_weight_sdp / _pdp / _cdp  in  8 each  WRR weights.
REQ-008 SHALL have port reg2dp_wr_os_cnt  in  8  outstanding-beat limit minus 1.
REQ-009 SHALL have ports eg2ig_axi_vld  in  1  and eg2ig_axi_len  in  2  write-response retire (len minus 1 beats).
REQ-010 SHALL have ports gnt_valid  out  1, gnt_ready  in  1, gnt_id  out  2, gnt_len  out  2  granted command toward split/convert stage.
REQ-011 SHALL have ports dat_busy  out  1, dat_sel  out  2, dat_accept  in  1  data-beat routing and beat handshake.
REQ-012 SHALL have ports os_used  out  9  current outstanding beats, os_err  out  1  sticky retire-underflow flag.

Function
REQ-013 SHALL implement FSM IDLE -> CMD -> DATA -> IDLE; one command in flight at a time.
REQ-014 IDLE: arbitrate each cycle; on a winner, register gnt_id/gnt_len, go CMD next cycle (req_valid -> gnt_valid latency 1 cycle).
REQ-015 Eligibility: req_valid[c]=1, wt_left[c]>0, and os_used + req_len[c] + 1 <= reg2dp_wr_os_cnt + 1 (9-bit compare).
REQ-016 Winner SHALL be first eligible client scanning ptr, ptr+1, ptr+2 (mod 3).
REQ-017 On winner registration, wt_left[winner] decrements by 1; if it reaches 0, ptr <= winner+1 mod 3, else ptr unchanged.
REQ-018 If some req_valid client passes credit but none has wt_left>0, reload all wt_left from weights that cycle, no grant (1-cycle bubble); weight 0 SHALL load as 1.
REQ-019 Credit-blocked clients SHALL not consume weight nor move ptr; no grant that cycle if nothing eligible.
REQ-020 CMD: gnt_valid=1, gnt_id/gnt_len held stable until gnt_ready; on handshake req_ready[gnt_id] pulses 1 cycle, os_used += gnt_len+1, go DATA.
REQ-021 Clients SHALL hold req_valid/req_len stable until req_ready; block does not re-sample req_len after IDLE.
REQ-022 DATA: dat_busy=1, dat_sel=gnt_id; beat counter increments on dat_accept; after gnt_len+1 beats go IDLE next cycle.
REQ-023 Retire: on eg2ig_axi_vld, os_used -= eg2ig_axi_len+1; simultaneous add and retire SHALL apply net in one cycle.
REQ-024 Underflow: if retire exceeds os_used (after same-cycle add), os_used saturates at 0 and os_err sets, cleared only by reset.
REQ-025 os_used SHALL never exceed 256; reg2dp_wr_os_cnt changes take effect at next arbitration, in-flight credit unaffected.
REQ-026 dat_accept outside DATA and gnt_ready outside CMD SHALL be ignored.

Reset
REQ-027 On nvdla_core_rstn=0 at a clock edge: state=IDLE, ptr=0, wt_left all 0 (forcing reload), os_used=0, os_err=0, beat count=0.
REQ-028 Reset outputs: gnt_valid=0, req_ready=0, dat_busy=0, gnt_id=0, gnt_len=0, dat_sel=0.
REQ-029 Reset mid-CMD/DATA SHALL abandon the command without req_ready pulse; no credit retained.

Verification
REQ-030 Weights sdp=2,pdp=1,cdp=1, all requesting len=0, os_cnt=255, gnt_ready/dat_accept=1 -> grant order 0,0,1,2,0,0,1,2 with one reload bubble each round.
REQ-031 os_cnt=3, client1 len=3 granted, no retire -> further requests blocked, os_used=4; eg2ig_axi_vld len=3 -> os_used=0, next grant 2 cycles later.
REQ-032 gnt_ready low 5 cycles in CMD -> gnt_valid/gnt_id/gnt_len stable, no req_ready, os_used unchanged until handshake.
REQ-033 Cmd accept len=1 same cycle as retire len=0 with os_used=3 -> os_used=4.
REQ-034 Retire len=3 with os_used=1 -> os_used=0, os_err=1 persists until reset.
REQ-035 Reset asserted mid-DATA beat 2 of 4 -> next cycle all outputs at reset values, ptr=0, os_used=0.
